// File: rtl/force_arbiter_if.sv
// Signal bundle between a stimulus/host side (master) and force_arbiter (slave).
// Strobes wr_en/req/rel are sampled on every rising edge, so the arbiter is always ready; gnt/forced/q report the result one edge later.
interface force_arbiter_if #(parameter int WIDTH = 4);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       req;
  logic [WIDTH-1:0] fval0;
  logic [WIDTH-1:0] fval1;
  logic [1:0]       rel;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] base_q;
  logic             forced;
  logic             state_dbg;

  modport master (
    output wr_en, wr_data, req, fval0, fval1, rel,
    input  gnt, q, base_q, forced, state_dbg
  );

  modport slave (
    input  wr_en, wr_data, req, fval0, fval1, rel,
    output gnt, q, base_q, forced, state_dbg
  );
endinterface

// File: rtl/force_arbiter.sv
// Two-requester force/release arbiter over a base register (IDLE/FORCED FSM, round-robin on ties).
// Optional auto-release after TIMEOUT forced cycles is enabled by defining FORCE_ARB_TIMEOUT_EN.
module force_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MIN = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  force_arbiter_if.slave bus
);
  // One counter width covers both the hold and the timeout counts.
  localparam int CMAX = (HOLD_MIN > TIMEOUT) ? HOLD_MIN : TIMEOUT;
  localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  typedef enum logic {IDLE = 1'b0, FORCED = 1'b1} state_t;

  state_t           state;
  logic [1:0]       gnt_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] fv_r;
  logic             ptr;
  logic [CW-1:0]    hold_cnt;

  logic             win;
  logic [WIDTH-1:0] win_val;
  logic [WIDTH-1:0] own_val;
  logic             own_req;
  logic             own_rel;
  logic             do_rel;
  logic             do_reforce;
  logic             release_now;

`ifdef FORCE_ARB_TIMEOUT_EN
  logic [CW-1:0]    to_cnt;
  logic             to_hit;
`endif

  always_comb begin
    win        = (bus.req == 2'b11) ? ptr : bus.req[1];
    win_val    = win ? bus.fval1 : bus.fval0;
    own_val    = gnt_r[1] ? bus.fval1 : bus.fval0;
    own_req    = |(bus.req & gnt_r);
    own_rel    = |(bus.rel & gnt_r);
    // A release wins over a same-cycle re-force even when the release is dropped.
    do_rel     = own_rel && (hold_cnt >= CW'(HOLD_MIN));
    do_reforce = own_req && !own_rel;
`ifdef FORCE_ARB_TIMEOUT_EN
    to_hit      = (to_cnt == CW'(TIMEOUT)) && !do_reforce;
    release_now = do_rel || to_hit;
`else
    release_now = do_rel;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_r    <= '0;
      q_r      <= '0;
      base_r   <= '0;
      fv_r     <= '0;
      ptr      <= 1'b0;
      hold_cnt <= '0;
`ifdef FORCE_ARB_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else if (state == IDLE) begin
      if (bus.wr_en) base_r <= bus.wr_data;
      if (bus.req != 2'b00) begin
        state    <= FORCED;
        gnt_r    <= win ? 2'b10 : 2'b01;
        fv_r     <= win_val;
        q_r      <= win_val;
        ptr      <= ~win;
        hold_cnt <= CW'(1);
`ifdef FORCE_ARB_TIMEOUT_EN
        to_cnt   <= CW'(1);
`endif
      end else begin
        q_r <= bus.wr_en ? bus.wr_data : base_r;
      end
    end else begin
      if (release_now) begin
        // Release commits the force value into the base register.
        state    <= IDLE;
        gnt_r    <= '0;
        base_r   <= fv_r;
        q_r      <= fv_r;
        hold_cnt <= '0;
`ifdef FORCE_ARB_TIMEOUT_EN
        to_cnt   <= '0;
`endif
      end else if (do_reforce) begin
        fv_r     <= own_val;
        q_r      <= own_val;
        hold_cnt <= CW'(1);
`ifdef FORCE_ARB_TIMEOUT_EN
        to_cnt   <= CW'(1);
`endif
      end else begin
        if (hold_cnt < CW'(HOLD_MIN)) hold_cnt <= hold_cnt + CW'(1);
`ifdef FORCE_ARB_TIMEOUT_EN
        to_cnt <= to_cnt + CW'(1);
`endif
      end
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.q         = q_r;
  assign bus.base_q    = base_r;
  assign bus.forced    = (state == FORCED);
  assign bus.state_dbg = (state == FORCED);
endmodule

// File: tb/tb_force_arbiter.sv
// Self-checking bench for force_arbiter: table of single-cycle vectors plus hand sequences for
// async reset, round-robin from reset and timeout / persistence of a force.
module tb_force_arbiter;
  localparam int W  = 4;
  localparam int EW = 2 * W + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  force_arbiter_if #(.WIDTH(W)) bus ();

  force_arbiter #(.WIDTH(W), .HOLD_MIN(2), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         wr_en;
    logic [W-1:0] wd;
    logic [1:0]   req;
    logic [1:0]   rel;
    logic [W-1:0] f0;
    logic [W-1:0] f1;
    logic [1:0]   gnt;
    logic [W-1:0] q;
    logic [W-1:0] bq;
    logic         fc;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  vec_t tbl[17];

  function automatic vec_t mk(input logic we, input logic [W-1:0] wd, input logic [1:0] req,
                              input logic [1:0] rel, input logic [W-1:0] f0, input logic [W-1:0] f1,
                              input logic [1:0] gnt, input logic [W-1:0] q, input logic [W-1:0] bq,
                              input logic fc);
    vec_t v;
    v.wr_en = we; v.wd = wd; v.req = req; v.rel = rel; v.f0 = f0; v.f1 = f1;
    v.gnt = gnt; v.q = q; v.bq = bq; v.fc = fc;
    return v;
  endfunction

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.req = 2'b00; bus.rel = 2'b00;
    bus.fval0 = '0; bus.fval1 = '0;
  endtask

  task automatic push_exp(input logic [1:0] gnt, input logic [W-1:0] q, input logic [W-1:0] bq,
                          input logic fc);
    exp_q.push_back({gnt, q, bq, fc, fc});
  endtask

  task automatic check_now(input string tag);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    e = exp_q.pop_front();
    a = {bus.gnt, bus.q, bus.base_q, bus.forced, bus.state_dbg};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got gnt=%b q=%h base_q=%h forced=%b state=%b, want gnt=%b q=%h base_q=%h forced=%b state=%b",
               tag, a[EW-1 -: 2], a[2*W+1 -: W], a[W+1 -: W], a[1], a[0],
               e[EW-1 -: 2], e[2*W+1 -: W], e[W+1 -: W], e[1], e[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    bus.wr_en = v.wr_en; bus.wr_data = v.wd; bus.req = v.req; bus.rel = v.rel;
    bus.fval0 = v.f0; bus.fval1 = v.f1;
    push_exp(v.gnt, v.q, v.bq, v.fc);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  // Reset pulsed low between edges; outputs must clear before the next rising edge.
  task automatic pulse_reset(input string tag);
    drive_idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push_exp(2'b00, '0, '0, 1'b0);
    check_now(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t idle_v;
    drive_idle();
    //            we  wd     req    rel    f0     f1     gnt    q      bq     fc
    tbl[0]  = mk(1, 4'h3, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h3, 4'h3, 0);
    tbl[1]  = mk(0, 4'h0, 2'b01, 2'b00, 4'h5, 4'h0, 2'b01, 4'h5, 4'h3, 1);
    tbl[2]  = mk(1, 4'hA, 2'b00, 2'b01, 4'h0, 4'h0, 2'b01, 4'h5, 4'h3, 1);
    tbl[3]  = mk(0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0, 2'b01, 4'h5, 4'h3, 1);
    tbl[4]  = mk(0, 4'h0, 2'b00, 2'b01, 4'h0, 4'h0, 2'b00, 4'h5, 4'h5, 0);
    tbl[5]  = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h5, 4'h5, 0);
    tbl[6]  = mk(0, 4'h0, 2'b11, 2'b00, 4'h1, 4'h2, 2'b10, 4'h2, 4'h5, 1);
    tbl[7]  = mk(0, 4'h0, 2'b10, 2'b00, 4'h0, 4'h7, 2'b10, 4'h7, 4'h5, 1);
    tbl[8]  = mk(1, 4'hC, 2'b01, 2'b00, 4'h9, 4'h0, 2'b10, 4'h7, 4'h5, 1);
    tbl[9]  = mk(0, 4'h0, 2'b10, 2'b10, 4'h0, 4'hE, 2'b00, 4'h7, 4'h7, 0);
    tbl[10] = mk(1, 4'h6, 2'b01, 2'b00, 4'h8, 4'h0, 2'b01, 4'h8, 4'h6, 1);
    tbl[11] = mk(0, 4'h0, 2'b00, 2'b01, 4'h0, 4'h0, 2'b01, 4'h8, 4'h6, 1);
    tbl[12] = mk(0, 4'h0, 2'b00, 2'b01, 4'h0, 4'h0, 2'b00, 4'h8, 4'h8, 0);
    tbl[13] = mk(0, 4'h0, 2'b11, 2'b00, 4'h3, 4'h4, 2'b10, 4'h4, 4'h8, 1);
    tbl[14] = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b10, 4'h4, 4'h8, 1);
    tbl[15] = mk(0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0, 2'b00, 4'h4, 4'h4, 0);
    tbl[16] = mk(0, 4'h0, 2'b11, 2'b00, 4'h3, 4'h4, 2'b01, 4'h3, 4'h4, 1);

    repeat (3) @(posedge clk);
    #1;
    push_exp(2'b00, '0, '0, 1'b0);
    check_now("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-force: the force value must not reach base_q.
    pulse_reset("rst_from_forced_tbl");
    apply(mk(1, 4'h3, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h3, 4'h3, 0), "rst_seq_wr3");
    apply(mk(0, 4'h0, 2'b01, 2'b00, 4'h5, 4'h0, 2'b01, 4'h5, 4'h3, 1), "rst_seq_force5");
    pulse_reset("async_rst_mid_force");
    apply(mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 0), "rst_no_commit");

    // Round-robin pointer starts at requester 0 after reset.
    apply(mk(0, 4'h0, 2'b11, 2'b00, 4'h1, 4'h2, 2'b01, 4'h1, 4'h0, 1), "rr_first");
    apply(mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h1, 4'h0, 1), "rr_hold0");
    apply(mk(0, 4'h0, 2'b00, 2'b01, 4'h0, 4'h0, 2'b00, 4'h1, 4'h1, 0), "rr_rel0");
    apply(mk(0, 4'h0, 2'b11, 2'b00, 4'h1, 4'h2, 2'b10, 4'h2, 4'h1, 1), "rr_second");
    apply(mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b10, 4'h2, 4'h1, 1), "rr_hold1");
    apply(mk(0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0, 2'b00, 4'h2, 4'h2, 0), "rr_rel1");

    apply(mk(0, 4'h0, 2'b01, 2'b00, 4'h5, 4'h0, 2'b01, 4'h5, 4'h2, 1), "long_force");
`ifdef FORCE_ARB_TIMEOUT_EN
    idle_v = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h5, 4'h2, 1);
    for (int c = 1; c < 15; c++) apply(idle_v, $sformatf("to_wait%0d", c));
    apply(mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h5, 4'h5, 0), "to_release");
    apply(mk(0, 4'h0, 2'b01, 2'b00, 4'h5, 4'h0, 2'b01, 4'h5, 4'h5, 1), "to2_force");
    idle_v = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h5, 4'h5, 1);
    for (int c = 1; c < 10; c++) apply(idle_v, $sformatf("to2_pre%0d", c));
    apply(mk(0, 4'h0, 2'b01, 2'b00, 4'h6, 4'h0, 2'b01, 4'h6, 4'h5, 1), "to2_reforce");
    idle_v = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h6, 4'h5, 1);
    for (int c = 11; c < 25; c++) apply(idle_v, $sformatf("to2_post%0d", c));
    apply(mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 4'h6, 4'h6, 0), "to2_release");
`else
    idle_v = mk(0, 4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 2'b01, 4'h5, 4'h2, 1);
    for (int c = 0; c < 30; c++) begin
      idle_v.wr_en = 1'b1;
      idle_v.wd    = W'($urandom_range(0, 15));
      apply(idle_v, $sformatf("persist%0d", c));
    end
    apply(mk(0, 4'h0, 2'b00, 2'b01, 4'h0, 4'h0, 2'b00, 4'h5, 4'h5, 0), "persist_release");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
